// File: rtl/freq_synthesizer_pkg.sv
// Shared helpers for the fractional strobe generator: port width and
// request saturation.
package freq_synthesizer_pkg;

  function automatic int calc_width(input int period);
    return $clog2(period + 1);
  endfunction

  function automatic int saturate(input int f, input int period);
    return (f > period) ? period : f;
  endfunction

endpackage

// File: rtl/freq_synthesizer_frac_accumulator.sv
// Phase accumulator: adds the rate every cycle and emits a registered tick
// on each wrap past PERIOD; clear realigns the phase at window boundaries.
module frac_accumulator
  import freq_synthesizer_pkg::*;
#(
  parameter int PERIOD = 1000,
  parameter int W      = calc_width(PERIOD)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [W-1:0] freq,
  output logic         tick
);

  localparam logic [W:0] PERIOD_X = (W + 1)'(PERIOD);

  logic [W-1:0] acc_reg;
  logic [W:0]   sum;
  logic         wrap;
  logic [W-1:0] acc_next;

  always_comb begin
    sum      = {1'b0, acc_reg} + {1'b0, freq};
    wrap     = (sum >= PERIOD_X);
    acc_next = wrap ? W'(sum - PERIOD_X) : sum[W-1:0];
  end

  // The boundary cycle still makes its tick decision; only the phase is reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_reg <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= wrap;
      acc_reg <= clear ? '0 : acc_next;
    end
  end

endmodule

// File: rtl/freq_synthesizer.sv
// Fractional strobe generator: F evenly spread ticks per PERIOD cycles.
// Optional square-wave output enabled by FREQ_SYNTHESIZER_SQWAVE_EN.
module freq_synthesizer
  import freq_synthesizer_pkg::*;
#(
  parameter int PERIOD = 1000,
  parameter int W      = calc_width(PERIOD)
) (
  input  logic         refclk,
  input  logic         reset_n,
  input  logic [W-1:0] freq_data,
  input  logic         freq_valid,
  output logic         freq_ready,
  output logic [W-1:0] freq_curr,
  output logic         window_stb,
  output logic         tick,
  output logic         sqwave
);

  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] pend_reg;
  logic         pend_vld_reg;
  logic         boundary;

  assign boundary   = (cnt_reg == LAST);
  assign freq_ready = ~pend_vld_reg;

  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      cnt_reg      <= '0;
      pend_reg     <= '0;
      pend_vld_reg <= 1'b0;
      freq_curr    <= '0;
      window_stb   <= 1'b0;
    end else begin
      cnt_reg    <= boundary ? '0 : cnt_reg + 1'b1;
      window_stb <= boundary;
      // Apply and accept are exclusive: ready is low whenever a value is pending.
      if (boundary && pend_vld_reg) begin
        freq_curr    <= pend_reg;
        pend_vld_reg <= 1'b0;
      end else if (freq_valid && !pend_vld_reg) begin
        pend_reg     <= W'(saturate(int'(freq_data), PERIOD));
        pend_vld_reg <= 1'b1;
      end
    end
  end

  frac_accumulator #(
    .PERIOD (PERIOD),
    .W      (W)
  ) u_acc (
    .clk     (refclk),
    .reset_n (reset_n),
    .clear   (boundary),
    .freq    (freq_curr),
    .tick    (tick)
  );

`ifdef FREQ_SYNTHESIZER_SQWAVE_EN
  logic sq_reg;

  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      sq_reg <= 1'b0;
    end else if (tick) begin
      sq_reg <= ~sq_reg;
    end
  end

  assign sqwave = sq_reg;
`else
  assign sqwave = 1'b0;
`endif

endmodule

// File: tb/tb_freq_synthesizer.sv
// Directed bench for freq_synthesizer with PERIOD = 10.
module tb_freq_synthesizer;

  localparam int PERIOD = 10;
  localparam int W      = 4;

  logic         refclk = 1'b0;
  logic         reset_n;
  logic [W-1:0] freq_data;
  logic         freq_valid;
  logic         freq_ready;
  logic [W-1:0] freq_curr;
  logic         window_stb;
  logic         tick;
  logic         sqwave;

  int checks = 0;
  int fails  = 0;

  freq_synthesizer #(.PERIOD(PERIOD)) dut (
    .refclk     (refclk),
    .reset_n    (reset_n),
    .freq_data  (freq_data),
    .freq_valid (freq_valid),
    .freq_ready (freq_ready),
    .freq_curr  (freq_curr),
    .window_stb (window_stb),
    .tick       (tick),
    .sqwave     (sqwave)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [3:0] data;
    logic [3:0] curr;
    logic [9:0] mask;  // bit j-1 = tick expected j cycles after window_stb
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_stb();
    int n;
    n = 0;
    step();
    while (!window_stb && n < 30) begin
      step();
      n++;
    end
    if (!window_stb) begin
      checks++;
      fails++;
      $display("FAIL wait_stb: timed out after %0d cycles", n);
    end
  endtask

  // Observes the 10 cycles after a window_stb; ends on the next window_stb.
  task automatic measure(output logic [9:0] m, output logic sq_any);
    m      = '0;
    sq_any = 1'b0;
    for (int j = 1; j <= PERIOD; j++) begin
      step();
      m[j-1] = tick;
      sq_any = sq_any | sqwave;
    end
  endtask

  task automatic check_window(input string name, input logic [9:0] exp_mask);
    logic [9:0] m;
    logic       sq_any;
    measure(m, sq_any);
    check({name, " tick mask"}, int'(m), int'(exp_mask));
    check({name, " stb at end"}, int'(window_stb), 1);
`ifndef FREQ_SYNTHESIZER_SQWAVE_EN
    check({name, " sqwave tied"}, int'(sq_any), 0);
`endif
  endtask

  initial begin
    logic [9:0] m;
    logic       sq_any;
    int         stb_count;
    int         first_stb;
    int         tick_count;
    int         n;

    vecs[0] = '{data: 4'd3,  curr: 4'd3,  mask: 10'b1001001000};
    vecs[1] = '{data: 4'd15, curr: 4'd10, mask: 10'b1111111111};
    vecs[2] = '{data: 4'd0,  curr: 4'd0,  mask: 10'b0000000000};
    vecs[3] = '{data: 4'd1,  curr: 4'd1,  mask: 10'b1000000000};
    vecs[4] = '{data: 4'd5,  curr: 4'd5,  mask: 10'b1010101010};
    vecs[5] = '{data: 4'd9,  curr: 4'd9,  mask: 10'b1111111110};
    vecs[6] = '{data: 4'd10, curr: 4'd10, mask: 10'b1111111111};

    reset_n    = 1'b0;
    freq_data  = 4'd7;
    freq_valid = 1'b1;  // must be ignored while in reset
    step();
    step();
    check("reset tick", int'(tick), 0);
    check("reset freq_curr", int'(freq_curr), 0);
    check("reset freq_ready", int'(freq_ready), 1);
    check("reset window_stb", int'(window_stb), 0);
    check("reset sqwave", int'(sqwave), 0);

    // Idle for 50 cycles after release
    freq_valid = 1'b0;
    reset_n    = 1'b1;
    stb_count  = 0;
    first_stb  = 0;
    tick_count = 0;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (window_stb) begin
        stb_count++;
        if (first_stb == 0) first_stb = c;
      end
      if (tick) tick_count++;
    end
    check("idle stb count", stb_count, 5);
    check("idle first stb", first_stb, 10);
    check("idle ticks", tick_count, 0);
    check("idle freq_curr", int'(freq_curr), 0);
    check("idle freq_ready", int'(freq_ready), 1);

    // Table: load at window start, apply at next boundary, measure one window
    for (int i = 0; i < 7; i++) begin
      wait_stb();
      freq_data  = vecs[i].data;
      freq_valid = 1'b1;
      step();
      freq_valid = 1'b0;
      check($sformatf("v%0d ready low after xfer", i), int'(freq_ready), 0);
      wait_stb();
      check($sformatf("v%0d freq_curr", i), int'(freq_curr), int'(vecs[i].curr));
      check($sformatf("v%0d ready after apply", i), int'(freq_ready), 1);
      check_window($sformatf("v%0d", i), vecs[i].mask);
    end

    // Back-to-back 4 then 7 with valid held
    wait_stb();
    freq_data  = 4'd4;
    freq_valid = 1'b1;
    step();
    check("b2b ready low after 4", int'(freq_ready), 0);
    freq_data = 4'd7;
    n = 0;
    while (!freq_ready && n < 30) begin
      step();
      n++;
    end
    check("b2b ready rises at stb", int'(window_stb), 1);
    check("b2b freq_curr 4", int'(freq_curr), 4);
    step();
    freq_valid = 1'b0;
    check("b2b ready low after 7", int'(freq_ready), 0);
    check("b2b curr still 4", int'(freq_curr), 4);
    // Window already one cycle in; observe remaining 9 cycles
    m = '0;
    m[0] = tick;
    for (int j = 2; j <= PERIOD; j++) begin
      step();
      m[j-1] = tick;
    end
    check("b2b window of 4 mask", int'(m), int'(10'b1010010100));
    check("b2b stb end", int'(window_stb), 1);
    check("b2b freq_curr 7", int'(freq_curr), 7);
    check_window("b2b window of 7", 10'b1110110110);

    // Transfer in the boundary cycle: applies only at the following boundary
    for (int j = 0; j < PERIOD - 1; j++) step();
    check("bnd ready before", int'(freq_ready), 1);
    freq_data  = 4'd2;
    freq_valid = 1'b1;
    step();
    freq_valid = 1'b0;
    check("bnd stb now", int'(window_stb), 1);
    check("bnd not applied", int'(freq_curr), 7);
    check("bnd ready low", int'(freq_ready), 0);
    check_window("bnd old rate", 10'b1110110110);
    check("bnd applied", int'(freq_curr), 2);
    check("bnd ready high", int'(freq_ready), 1);
    check_window("bnd new rate", 10'b1000010000);

    // Reset mid-window with a value pending
    freq_data  = 4'd6;
    freq_valid = 1'b1;
    step();
    freq_valid = 1'b0;
    check("rst pending", int'(freq_ready), 0);
    step();
    step();
    reset_n = 1'b0;
    step();
    check("rst tick", int'(tick), 0);
    check("rst freq_curr", int'(freq_curr), 0);
    check("rst freq_ready", int'(freq_ready), 1);
    check("rst window_stb", int'(window_stb), 0);
    check("rst sqwave", int'(sqwave), 0);
    reset_n    = 1'b1;
    tick_count = 0;
    stb_count  = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (tick) tick_count++;
      if (window_stb) stb_count++;
    end
    check("rst pending lost curr", int'(freq_curr), 0);
    check("rst no ticks", tick_count, 0);
    check("rst stb count", stb_count, 2);
    check("rst ready after", int'(freq_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
